// File: rtl/ibus_sram_responder_if.sv
// ibus_if: instruction-bus request/response handshake between fetch (master) and memory (slave)
interface ibus_if;
  logic        valid;
  logic [31:0] addr;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] data;
  modport master (output valid, addr, input addr_ok, data_ok, data);
  modport slave  (input valid, addr, output addr_ok, data_ok, data);
endinterface

// File: rtl/ibus_sram_responder.sv
// ibus_sram_responder: in-order ibus responder with fixed-latency instruction RAM and backdoor load
module ibus_sram_responder #(
  parameter int          MEM_WORDS = 1024,
  parameter int          LATENCY   = 2,
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'hbfc0_0000
) (
  input  logic        clk,
  input  logic        resetn,
  ibus_if.slave       ibus,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(LATENCY) + 1;
  localparam int QW = $clog2(DEPTH) + 1;
  logic [31:0]   mem [MEM_WORDS];
  logic [31:0]   addr_q [DEPTH];
  logic [CW-1:0] cnt_q [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [QW-1:0] count;
  logic [31:0]   head_off, load_off;
  logic          head_hit, load_hit, full, push, pop;
  assign head_off = addr_q[rp] - BASE_ADDR;
  assign load_off = load_addr - BASE_ADDR;
  assign head_hit = head_off[1:0] == 2'b00 && head_off[31:AW+2] == '0;
  assign load_hit = load_off[1:0] == 2'b00 && load_off[31:AW+2] == '0;
  assign push = ibus.addr_ok;
  assign pop  = ibus.data_ok;
  // Handshake outputs; a pop never frees a slot for the same cycle's request
  always_comb begin
    full = count == QW'(DEPTH);
    ibus.addr_ok = resetn && ibus.valid && !full;
    ibus.data_ok = count != '0 && cnt_q[rp] == '0;
    ibus.data = ibus.data_ok && head_hit ? mem[head_off[AW+1:2]] : 32'h0;
  end
  // Backdoor program load; RAM contents survive reset
  always_ff @(posedge clk)
    if (load_en && load_hit) mem[load_off[AW+1:2]] <= load_data;
  // Request queue: in-order entries each counting down to its response cycle
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      if (push) addr_q[wp] <= ibus.addr;
      if (push) wp <= wp == PW'(DEPTH - 1) ? '0 : wp + 1'b1;
      if (pop) rp <= rp == PW'(DEPTH - 1) ? '0 : rp + 1'b1;
      count <= count + QW'(push) - QW'(pop);
      for (int i = 0; i < DEPTH; i++)
        cnt_q[i] <= push && wp == PW'(i) ? CW'(LATENCY - 1) : cnt_q[i] - CW'(cnt_q[i] != '0);
    end
endmodule
